// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_pkg
// Description : Shared types and constants for the turn-signal command
//               generator: sequencer states, step type, one-hot commands.
// Revision    : 1.0 - initial release
// ============================================================================
package blink_pkg;

    // Sequencer states; a sequence is IDLE tick plus three SEQ ticks
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LEFT_SEQ  = 2'd1,
        RIGHT_SEQ = 2'd2
    } state_t;

    // Step counter inside a sequence (1..3 while in a SEQ state)
    typedef logic [1:0] step_t;

    localparam step_t STEP_FIRST = 2'd1;
    localparam step_t STEP_LAST  = 2'd3;

    // One-hot command encoding: bit0 noop, bit1 left, bit2 right
    localparam logic [2:0] CMD_NOOP  = 3'b001;
    localparam logic [2:0] CMD_LEFT  = 3'b010;
    localparam logic [2:0] CMD_RIGHT = 3'b100;

endpackage : blink_pkg
`default_nettype wire

// File: rtl/blink_debounce.sv
`default_nettype none
// ============================================================================
// Module      : blink_debounce
// Description : Two-flop synchroniser followed by a level debouncer. The
//               debounced level follows the synchronised input only after
//               it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_db) begin
            if (r_cnt == C_CNT_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_db = r_db;

endmodule : blink_debounce
`default_nettype wire

// File: rtl/blink_command_gen.sv
`default_nettype none
// ============================================================================
// Module      : blink_command_gen
// Description : Debounces the left/right buttons, divides clk into a blink
//               tick and issues exactly one command (left/right/noop) per
//               tick so the downstream lamp state walks a 4-tick sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_command_gen
    import blink_pkg::*;
#(
    parameter int TICK_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    output logic tick_o,
    output logic c_left,
    output logic c_right,
    output logic c_noop,
    output logic busy_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

    logic          w_db_left;
    logic          w_db_right;
    logic [PW-1:0] r_presc;
    logic          w_tick_int;
    state_t        r_state;
    state_t        w_state_nxt;
    step_t         r_step;
    step_t         w_step_nxt;
    logic [2:0]    w_cmd;
    logic [2:0]    r_cmd;
    logic          r_tick;

    blink_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk   (clk),
        .rst_n (rst_n),
        .i_btn (btn_left),
        .o_db  (w_db_left)
    );

    blink_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk   (clk),
        .rst_n (rst_n),
        .i_btn (btn_right),
        .o_db  (w_db_right)
    );

    // Free-running prescaler 0..TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_presc == C_PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick_int = (r_presc == C_PRESC_LAST);

    // Sequencer state register, updated on the edge that registers the command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next-state and command selection; only acts on the internal tick
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cmd       = CMD_NOOP;
        if (w_tick_int) begin
            case (r_state)
                IDLE: begin
                    if (w_db_left && !w_db_right) begin
                        w_cmd       = CMD_LEFT;
                        w_state_nxt = LEFT_SEQ;
                        w_step_nxt  = STEP_FIRST;
                    end else if (w_db_right && !w_db_left) begin
                        w_cmd       = CMD_RIGHT;
                        w_state_nxt = RIGHT_SEQ;
                        w_step_nxt  = STEP_FIRST;
                    end
                end
                LEFT_SEQ: begin
                    if (r_step == STEP_LAST) begin
                        w_state_nxt = IDLE;
                        w_step_nxt  = '0;
                    end else begin
                        if (w_db_left) begin
                            w_cmd = CMD_LEFT;
                        end
                        w_step_nxt = r_step + 2'd1;
                    end
                end
                RIGHT_SEQ: begin
                    if (r_step == STEP_LAST) begin
                        w_state_nxt = IDLE;
                        w_step_nxt  = '0;
                    end else begin
                        if (w_db_right) begin
                            w_cmd = CMD_RIGHT;
                        end
                        w_step_nxt = r_step + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_step_nxt  = '0;
                end
            endcase
        end
    end

    // Registered strobe and command; commands are forced low between ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
            r_cmd  <= '0;
        end else begin
            r_tick <= w_tick_int;
            r_cmd  <= w_tick_int ? w_cmd : 3'b000;
        end
    end

    assign tick_o  = r_tick;
    assign c_noop  = r_cmd[0];
    assign c_left  = r_cmd[1];
    assign c_right = r_cmd[2];
    assign busy_o  = (r_state != IDLE);

endmodule : blink_command_gen
`default_nettype wire

// File: tb/tb_blink_command_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_command_gen
// Description : Directed bench with an expected-command queue; each tick
//               pops one expected {command, busy} pair and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_command_gen;

    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 3;

    // Bench-side command codes, packed as {c_right, c_left, c_noop}
    localparam logic [2:0] E_N = 3'b001;
    localparam logic [2:0] E_L = 3'b010;
    localparam logic [2:0] E_R = 3'b100;

    typedef struct packed {
        logic [2:0] cmd;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;
    logic btn_left;
    logic btn_right;
    logic tick_o;
    logic c_left;
    logic c_right;
    logic c_noop;
    logic busy_o;

    exp_t q[$];
    int   checks;
    int   failures;
    int   cyc;

    blink_command_gen #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .tick_o    (tick_o),
        .c_left    (c_left),
        .c_right   (c_right),
        .c_noop    (c_noop),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] cmd, input logic busy);
        exp_t e;
        e.cmd  = cmd;
        e.busy = busy;
        q.push_back(e);
    endtask

    // Advance n cycles; ticks are due every TICK_DIV cycles after release
    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((cyc % TICK_DIV) == 0) begin
                check("tick_due", {7'd0, tick_o}, 8'd1);
                if (q.size() == 0) begin
                    check("queue_underflow", 8'd1, 8'd0);
                end else begin
                    e = q.pop_front();
                    check("cmd", {5'd0, c_right, c_left, c_noop}, {5'd0, e.cmd});
                    check("busy", {7'd0, busy_o}, {7'd0, e.busy});
                end
            end else begin
                check("no_tick", {4'd0, tick_o, c_right, c_left, c_noop}, 8'd0);
            end
        end
    endtask

    task automatic do_reset(input logic left, input logic right);
        rst_n     = 1'b0;
        btn_left  = left;
        btn_right = right;
        q.delete();
        @(posedge clk);
        #1;
        check("reset_outs", {3'd0, tick_o, c_right, c_left, c_noop, busy_o}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic end_scenario(input string tag);
        check(tag, 8'(q.size()), 8'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;

        // Idle: noop every tick, never busy
        do_reset(1'b0, 1'b0);
        repeat (5) push(E_N, 1'b0);
        run(20);
        end_scenario("idle_done");

        // Short pulses (1 and 2 synced cycles) never pass the debouncer
        do_reset(1'b0, 1'b0);
        repeat (5) push(E_N, 1'b0);
        run(1);
        btn_left = 1'b1;
        run(1);
        btn_left = 1'b0;
        run(3);
        btn_left = 1'b1;
        run(2);
        btn_left = 1'b0;
        run(14);
        end_scenario("pulse_done");

        // Left held from reset: first tick noop, then L L L N repeating
        do_reset(1'b1, 1'b0);
        push(E_N, 1'b0);
        repeat (2) begin
            push(E_L, 1'b1);
            push(E_L, 1'b1);
            push(E_L, 1'b1);
            push(E_N, 1'b0);
        end
        run(36);
        end_scenario("held_done");

        // Left released so the debounced level falls before step 1
        do_reset(1'b1, 1'b0);
        push(E_N, 1'b0);
        push(E_L, 1'b1);
        push(E_N, 1'b1);
        push(E_N, 1'b1);
        push(E_N, 1'b0);
        push(E_N, 1'b0);
        run(6);
        btn_left = 1'b0;
        run(18);
        end_scenario("release_done");

        // Both held: always noop
        do_reset(1'b1, 1'b1);
        repeat (5) push(E_N, 1'b0);
        run(20);
        end_scenario("both_done");

        // Right pressed mid left sequence is ignored until the IDLE tick
        do_reset(1'b1, 1'b0);
        push(E_N, 1'b0);
        push(E_L, 1'b1);
        push(E_L, 1'b1);
        push(E_N, 1'b1);
        push(E_N, 1'b0);
        push(E_R, 1'b1);
        push(E_R, 1'b1);
        push(E_R, 1'b1);
        push(E_N, 1'b0);
        run(9);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        run(27);
        end_scenario("opposite_done");

        // Reset asserted during LEFT_SEQ step 2
        do_reset(1'b1, 1'b0);
        push(E_N, 1'b0);
        push(E_L, 1'b1);
        push(E_L, 1'b1);
        run(13);
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {3'd0, tick_o, c_right, c_left, c_noop, busy_o}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        push(E_N, 1'b0);
        push(E_L, 1'b1);
        run(8);
        end_scenario("midreset_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_blink_command_gen
`default_nettype wire

// File: doc/blink_command_gen.md
# blink_command_gen

Command source for the turn-signal sequencer's next-state logic. Synchronises and debounces the left/right pushbuttons, divides the system clock into a blink tick, and on every tick issues exactly one command (left, right or noop) so that the downstream 2-bit lamp state walks 00→01→10→11→00 and returns to 00. It is the producer end of the c_left/c_noop command interface and owns all timing; the next-state logic stays purely combinational and registers on tick_o.

## Interface
- TICK_DIV, 12_500_000: clock cycles per blink tick (≥2).
- DEBOUNCE_CYCLES, 250_000: consecutive stable synchronised samples required to accept a new button level (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock.
- btn_left  in  1  raw asynchronous left button, active-high.
- btn_right  in  1  raw asynchronous right button, active-high.
- tick_o  out  1  one-cycle blink-tick strobe; lamp state register enable.
- c_left  out  1  left command, valid only while tick_o=1.
- c_right  out  1  right command, valid only while tick_o=1.
- c_noop  out  1  noop command, valid only while tick_o=1.
- busy_o  out  1  high while a 4-tick sequence is in progress.

## Operation
- Input path per button: 2-flop synchroniser, then debouncer; debounced level db_x changes only after the synchronised level differs from db_x for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
- Prescaler: counts 0..TICK_DIV-1, wraps to 0; internal tick_int when count = TICK_DIV-1.
- Sequencer states: IDLE, LEFT_SEQ, RIGHT_SEQ; 2-bit step counter (1..3) in SEQ states.
- On tick_int in IDLE: db_left & ~db_right → c_left, go LEFT_SEQ step 1; db_right & ~db_left → c_right, go RIGHT_SEQ step 1; both or neither → c_noop, stay IDLE.
- On tick_int in LEFT_SEQ step 1 or 2: c_left if db_left else c_noop; step+1.
- On tick_int in LEFT_SEQ step 3: c_noop unconditionally; go IDLE. RIGHT_SEQ mirrors with db_right/c_right.
- Opposite button during a sequence is ignored; it is evaluated only at the next IDLE tick. No queuing of requests.
- Held button: sequences repeat back-to-back (IDLE tick immediately restarts), producing period 4 ticks.
- Exactly one of c_left/c_right/c_noop is high when tick_o=1; all three low otherwise.
- busy_o = state ≠ IDLE.

## Timing
- Reset (async assert, sync-to-clk release irrelevant here): tick_o=0, c_left=0, c_right=0, c_noop=0, busy_o=0, state IDLE, prescaler 0, synchronisers 0, debounced levels 0, debounce counters 0.
- Outputs are registered: tick_o and command assert in the cycle after prescaler count = TICK_DIV-1; first tick_o after reset release at cycle TICK_DIV (counting first active edge as 1).
- State/step update on the same edge that registers the command.
- Button-to-debounced latency: 2 (sync) + DEBOUNCE_CYCLES cycles; a request is sampled at the first tick_int at or after db_x goes high.
- Reset asserted mid-sequence: immediate return to IDLE, outputs low; no partial command emitted.
- Press shorter than DEBOUNCE_CYCLES: never seen. Press released before tick: no command.

## Structure
- Package blink_pkg: state enum (IDLE, LEFT_SEQ, RIGHT_SEQ), 2-bit step type, command one-hot encoding constants (CMD_NOOP, CMD_LEFT, CMD_RIGHT).
- Sub-module blink_debounce (synchroniser + counter, DEBOUNCE_CYCLES parameter), instantiated once per button. Prescaler and sequencer inline.

## Test plan (TICK_DIV=4, DEBOUNCE_CYCLES=3)
- Idle, no buttons, 20 cycles after reset → tick_o every 4 cycles, c_noop each tick, busy_o=0.
- btn_left 1-cycle pulse then 2-cycle pulse → no debounced change, only c_noop ticks.
- btn_left held from cycle 1 → first tick after debounce gives c_left, busy_o=1; next ticks c_left, c_left, c_noop; then c_left again (repeat).
- btn_left pressed then released after first c_left → sequence c_left, c_noop, c_noop, c_noop; IDLE after 4th tick.
- Both buttons held → c_noop every tick; btn_right asserted during LEFT_SEQ → ignored until IDLE tick, then c_right.
- rst_n low for 1 cycle at LEFT_SEQ step 2 → all outputs 0 immediately, busy_o=0; next tick_o TICK_DIV cycles after release.
